// File: rtl/mem_resp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_resp_pkg : shared types and helpers for the mem_responder slice        |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package mem_resp_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Range test in 33 bits so base + size never wraps past 2^32.
  function automatic logic addr_in_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [32:0] bytes
  );
    logic [32:0] a;
    logic [32:0] b;
    a = {1'b0, addr};
    b = {1'b0, base};
    return (a >= b) && (a < (b + bytes));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_resp_sram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_resp_sram : single-port word RAM, synchronous read, byte-enable write  |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module mem_resp_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Kept in RAM-template form so the array maps onto a block RAM; the read
  // register only loads on an enabled read, so the word holds until reused.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[index][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
    if (en && !we) begin
      rdata_q <= mem[index];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_responder : req/rvalid memory responder with fixed wait states         |
// | Optional write protection window enabled by MEM_RESP_WPROT_EN.             |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] WP_BASE     = 32'h0,
  parameter logic [31:0] WP_LIMIT    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        fault
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);
  localparam logic [3:0]  CNT_LAST   = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cap_we_q, cap_we_d;
  logic        cap_fault_q, cap_fault_d;
  logic        rvalid_q, rvalid_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;

  logic             accept;
  logic             misaligned;
  logic             out_of_range;
  logic             wr_protected;
  logic             req_fault;
  logic             sram_en;
  logic [IDX_W-1:0] sram_index;
  logic [31:0]      sram_rdata;

  // ---------------------------------------------------------------------------
  // Fault decode on the live request; only meaningful on the accept edge.
  // ---------------------------------------------------------------------------
  assign misaligned   = |addr[1:0];
  assign out_of_range = !addr_in_range(addr, BASE_ADDR, SPAN_BYTES);

`ifdef MEM_RESP_WPROT_EN
  // An empty window (WP_BASE == WP_LIMIT) can never match.
  assign wr_protected = we && (addr >= WP_BASE) && (addr < WP_LIMIT);
`else
  logic unused_wp;
  assign unused_wp    = ^{WP_BASE, WP_LIMIT};
  assign wr_protected = 1'b0;
`endif

  assign req_fault = misaligned | out_of_range | wr_protected;

  // ---------------------------------------------------------------------------
  // RAM port: writes commit and reads are captured on the accept edge itself.
  // ---------------------------------------------------------------------------
  assign accept     = (state_q == IDLE) && req;
  assign sram_en    = accept && !req_fault;
  assign sram_index = IDX_W'((addr - BASE_ADDR) >> 2);

  mem_resp_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (we),
    .be    (be),
    .index (sram_index),
    .wdata (wdata),
    .rdata (sram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Next-state, wait counter and response formation
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_we_d    = cap_we_q;
    cap_fault_d = cap_fault_q;
    rvalid_d    = 1'b0;
    fault_d     = 1'b0;
    rdata_d     = 32'h0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          cap_we_d    = we;
          cap_fault_d = req_fault;
          cnt_d       = 4'd0;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        // Writes and faulted accesses respond with zero data.
        state_d  = IDLE;
        rvalid_d = 1'b1;
        fault_d  = cap_fault_q;
        if (!cap_fault_q && !cap_we_q) begin
          rdata_d = sram_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cap_we_q    <= 1'b0;
      cap_fault_q <= 1'b0;
      rvalid_q    <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_we_q    <= cap_we_d;
      cap_fault_q <= cap_fault_d;
      rvalid_q    <= rvalid_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign fault  = fault_q;
  assign rdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_responder : scoreboard bench, instances with 1, 0 and 3 wait states |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_mem_responder;

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    bit          chk_data;
    int          due;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n_v  [3];
  logic        req_v    [3];
  logic        we_v     [3];
  logic [3:0]  be_v     [3];
  logic [31:0] addr_v   [3];
  logic [31:0] wdata_v  [3];
  logic [31:0] rdata_v  [3];
  logic        rvalid_v [3];
  logic        fault_v  [3];

  exp_t sb [3][$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   drv_done = 1'b0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0),
      .WAIT_STATES (ws_of(g)),
      .WP_BASE     (32'h100),
      .WP_LIMIT    (32'h200)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n_v[g]),
      .req    (req_v[g]),
      .we     (we_v[g]),
      .be     (be_v[g]),
      .addr   (addr_v[g]),
      .wdata  (wdata_v[g]),
      .rdata  (rdata_v[g]),
      .rvalid (rvalid_v[g]),
      .fault  (fault_v[g])
    );
  end

  // Present a request at the current negedge, queue its expected response,
  // then wait (bounded) for the rvalid cycle of this request.
  task automatic issue(input int k, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input bit ef, input bit cd,
                       input string nm);
    exp_t e;
    int   t;
    req_v[k]   = 1'b1;
    we_v[k]    = w;
    be_v[k]    = b;
    addr_v[k]  = a;
    wdata_v[k] = d;
    e.rdata    = er;
    e.fault    = ef;
    e.chk_data = cd;
    e.due      = cyc + 2 + ws_of(k);
    e.name     = nm;
    sb[k].push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rvalid_v[k] && t < 40);
  endtask

  task automatic drop_req(input int k);
    req_v[k] = 1'b0;
    we_v[k]  = 1'b0;
  endtask

  // Monitor: checks reset state, pops the scoreboard on every response.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n_v[k]) begin
        n_vec++;
        if (rvalid_v[k] !== 1'b0 || fault_v[k] !== 1'b0 || rdata_v[k] !== 32'h0) begin
          n_err++;
          $display("FAIL reset_state[%0d]: got rvalid=%b fault=%b rdata=%h, required 0 0 00000000",
                   k, rvalid_v[k], fault_v[k], rdata_v[k]);
        end
      end else if (rvalid_v[k]) begin
        n_vec++;
        if (sb[k].size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rvalid[%0d]: got rvalid=1 at cycle %0d, required no response",
                   k, cyc);
        end else begin
          e = sb[k].pop_front();
          if (fault_v[k] !== e.fault || cyc != e.due ||
              (e.chk_data && rdata_v[k] !== e.rdata)) begin
            n_err++;
            $display("FAIL %s[%0d]: got rdata=%h fault=%b cycle=%0d, required rdata=%h fault=%b cycle=%0d",
                     e.name, k, rdata_v[k], fault_v[k], cyc, e.rdata, e.fault, e.due);
          end
        end
      end
    end
    if (drv_done) begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (sb[k].size() != 0) begin
          n_err++;
          $display("FAIL lost_response[%0d]: got %0d responses outstanding, required 0",
                   k, sb[k].size());
        end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n_v[k] = 1'b0;
      req_v[k]   = 1'b0;
      we_v[k]    = 1'b0;
      be_v[k]    = 4'h0;
      addr_v[k]  = 32'h0;
      wdata_v[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) rst_n_v[k] = 1'b1;
    @(negedge clk);

    // Instance 0, one wait state: write/read, byte enables, faults, boundaries
    issue(0, 1, 4'hF, 32'h10,  32'hDEAD_BEEF, 32'h0,         0, 1, "wr_full");
    issue(0, 0, 4'hF, 32'h10,  32'h0,         32'hDEAD_BEEF, 0, 1, "rd_full");
    issue(0, 1, 4'h5, 32'h10,  32'h1122_3344, 32'h0,         0, 1, "wr_be5");
    issue(0, 0, 4'h0, 32'h10,  32'h0,         32'hDE22_BE44, 0, 1, "rd_be5");
    issue(0, 0, 4'hF, 32'h13,  32'h0,         32'h0,         1, 1, "rd_misaligned");
    issue(0, 0, 4'hF, 32'h1000,32'h0,         32'h0,         1, 1, "rd_past_end");
    issue(0, 1, 4'hF, 32'h12,  32'hCAFE_F00D, 32'h0,         1, 1, "wr_misaligned");
    issue(0, 1, 4'hF, 32'h1000,32'hCAFE_F00D, 32'h0,         1, 1, "wr_past_end");
    issue(0, 1, 4'hF, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'h0,   1, 1, "wr_top_addr");
    issue(0, 0, 4'hF, 32'h10,  32'h0,         32'hDE22_BE44, 0, 1, "rd_unchanged");
    issue(0, 1, 4'hF, 32'hFFC, 32'h0BAD_F00D, 32'h0,         0, 1, "wr_last_word");
    issue(0, 0, 4'hF, 32'hFFC, 32'h0,         32'h0BAD_F00D, 0, 1, "rd_last_word");
    issue(0, 1, 4'h0, 32'h10,  32'hFFFF_FFFF, 32'h0,         0, 1, "wr_be0");
    issue(0, 0, 4'hF, 32'h10,  32'h0,         32'hDE22_BE44, 0, 1, "rd_after_be0");

    // Reset while waiting after a write accept: no response, write persists
    req_v[0]   = 1'b1;
    we_v[0]    = 1'b1;
    be_v[0]    = 4'hF;
    addr_v[0]  = 32'h20;
    wdata_v[0] = 32'h55AA_1234;
    @(negedge clk);
    #1;
    rst_n_v[0] = 1'b0;
    drop_req(0);
    repeat (3) @(negedge clk);
    #1;
    rst_n_v[0] = 1'b1;
    @(negedge clk);
    issue(0, 0, 4'hF, 32'h20,  32'h0,         32'h55AA_1234, 0, 1, "rd_after_reset");

`ifdef MEM_RESP_WPROT_EN
    issue(0, 1, 4'hF, 32'h100, 32'h1234_5678, 32'h0,         1, 1, "wp_wr_base");
    issue(0, 0, 4'hF, 32'h100, 32'h0,         32'h0,         0, 0, "wp_rd_base");
    issue(0, 1, 4'hF, 32'h1FC, 32'h1234_5678, 32'h0,         1, 1, "wp_wr_last");
    issue(0, 1, 4'hF, 32'h200, 32'h5A5A_5A5A, 32'h0,         0, 1, "wp_wr_limit");
    issue(0, 0, 4'hF, 32'h200, 32'h0,         32'h5A5A_5A5A, 0, 1, "wp_rd_limit");
    issue(0, 1, 4'hF, 32'hFC,  32'h0F0F_0F0F, 32'h0,         0, 1, "wp_wr_below");
`endif
    drop_req(0);

    // Instances 1 (no wait) and 2 (three waits): req held high throughout
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 8; i++) begin
        if ((i % 2) == 0) begin
          issue(k, 1, 4'hF, 32'h40 + 32'(4 * (i / 2)),
                32'hA500_0000 | 32'(k << 8) | 32'(i), 32'h0, 0, 1, "stream_wr");
        end else begin
          issue(k, 0, 4'hF, 32'h40 + 32'(4 * (i / 2)), 32'h0,
                32'hA500_0000 | 32'(k << 8) | 32'(i - 1), 0, 1, "stream_rd");
        end
      end
      drop_req(k);
    end

    repeat (6) @(negedge clk);
    #1;
    drv_done = 1'b1;
  end

endmodule
`default_nettype wire
